fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch and program-counter stage sitting directly upstream of the control decoder. Alternates FETCH and EXEC phases: in FETCH it latches the ROM byte at `pc` into `ir`; in EXEC it presents `ir` to the decoder and consumes the decoder's `doJumpBar` and `assertRom`. It advances `pc` past an immediate operand or loads a jump target from the data bus. It also flags a self-loop halt.

## Interface
- `RESET_PC`, 8'h00, `pc` value after reset
- `clk`  in  1  system clock; all state updates on rising edge
- `resetBar`  in  1  synchronous reset, active-low
- `romData`  in  8  ROM byte at address `pc`, combinational from ROM
- `dbus`  in  8  data bus value during EXEC; this is the jump target
- `doJumpBar`  in  1  from decoder, active-low; sampled only in EXEC
- `assertRom`  in  1  from decoder; current instruction reads an immediate from ROM; sampled only in EXEC
- `pc`  out  8  ROM address
- `ir`  out  8  instruction register, feeds decoder `ir`
- `execPhase`  out  1  high in EXEC; downstream gates triggers/stores with it
- `instrAddr`  out  8  address the current `ir` was fetched from
- `halted`  out  1  sticky self-loop detect

## Operation
- Reset (`resetBar`=0 at an edge): `pc`=RESET_PC, `ir`=8'h00, `instrAddr`=8'h00, state=FETCH, `execPhase`=0, `halted`=0. Reset overrides every other input, in any phase.
- Two states: FETCH and EXEC. `execPhase`=1 iff state=EXEC.
- FETCH → EXEC, unconditional:
  - `ir`<=`romData`
  - `instrAddr`<=`pc`
  - `pc`<=`pc`+1
- EXEC → FETCH, unconditional. Priority:
  - `doJumpBar`=0 → `pc`<=`dbus`. The jump wins even when `assertRom`=1; the immediate is the target and is not skipped separately.
  - else `assertRom`=1 → `pc`<=`pc`+1, skipping the immediate.
  - else `pc` holds.
- `ir` and `instrAddr` hold through EXEC.
- Halt detect: in EXEC with `doJumpBar`=0 and `dbus`==`instrAddr`, set `halted`<=1. It clears only on reset. The sequencer keeps running the loop.
- Arithmetic is modulo 256. `pc` wraps 8'hFF→8'h00 on increment, in both the FETCH increment and the immediate skip. There is no carry-out and no error.
- `doJumpBar`, `assertRom` and `dbus` are ignored in FETCH. Decoder outputs during FETCH are don't-care.

## Timing
- One instruction every 2 cycles.
- `ir` is valid from the edge that leaves FETCH until the next FETCH edge.
- `pc` during EXEC points at the immediate byte (`instrAddr`+1), so `romData`/`dbus` carries the immediate in EXEC.
- Jump target is visible on `pc` the cycle after the EXEC edge, i.e. in the following FETCH.
- `halted` rises at the same edge that loads the jump target.
- All outputs are registered except `execPhase`, which is a direct decode of the state flop (also registered-clean).
- Reset asserted during EXEC: the pending jump or increment is discarded, and the next cycle is FETCH at RESET_PC.

## Structure
- Shared package `nic8_pkg`:
  - `PHASE_FETCH`/`PHASE_EXEC` state encoding (1 bit, FETCH=0)
  - `ADDR_W`=8, `DATA_W`=8
- Natural sub-module: `pc_counter`, an 8-bit register with sync active-low reset, load, and increment enable, with load priority over increment. Implementable as two LS161-style nibble counters to match the gate-level style.
- The top level holds the phase flop, `ir`/`instrAddr` registers and the halt flop.

## Test plan
- Reset with RESET_PC=8'h00, ROM[0]=8'h2A:
  - After the reset edge: `pc`=00, `ir`=00, `execPhase`=0, `halted`=0.
  - One edge later: `ir`=2A, `pc`=01, `instrAddr`=00, `execPhase`=1.
- Straight-line immediate: EXEC with `assertRom`=1, `doJumpBar`=1 and `pc`=01 → `pc`=02. With `assertRom`=0 → `pc` stays 01.
- Jump: EXEC with `doJumpBar`=0, `assertRom`=1, `dbus`=8'h40 → `pc`=40. Next FETCH latches ROM[40] into `ir`; `instrAddr`=40.
- Wrap: instruction at 8'hFE with an immediate → FETCH makes `pc`=FF, EXEC skip makes `pc`=00, no glitch or stall.
- Halt: instruction at 8'h10, jump with `dbus`=8'h10 → `halted`=1, `pc`=10. The loop continues, and `halted` stays 1 until `resetBar`=0.
- Reset mid-EXEC: `resetBar`=0 during EXEC with `doJumpBar`=0 and `dbus`=8'h80 → `pc`=RESET_PC (not 80), FETCH, `halted`=0.

Source files
------------

// File: rtl/nic8_pkg.sv
// Shared definitions for the nic8 fetch/decode slice: phase encoding and bus widths.
package nic8_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic {
        PHASE_FETCH = 1'b0,
        PHASE_EXEC  = 1'b1
    } phase_e;

endpackage

// File: rtl/pc_counter.sv
// 8-bit program counter built as two cascaded nibble counters in the LS161 manner:
// synchronous active-low reset, parallel load with priority, and count enable.
module pc_counter
    import nic8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              resetBar,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadValue,
    input  logic              incEn,
    output logic [ADDR_W-1:0] count
);

    logic [3:0] loNibble_q;
    logic [3:0] loNibble_d;
    logic [3:0] hiNibble_q;
    logic [3:0] hiNibble_d;
    logic       loCarry;

    // Terminal count of the low nibble enables the high nibble, so FF+1 wraps to 00.
    assign loCarry = incEn && (loNibble_q == 4'hF);

    always_comb begin
        loNibble_d = loNibble_q;
        hiNibble_d = hiNibble_q;
        if (load) begin
            loNibble_d = loadValue[3:0];
            hiNibble_d = loadValue[7:4];
        end else begin
            if (incEn) begin
                loNibble_d = loNibble_q + 4'd1;
            end
            if (loCarry) begin
                hiNibble_d = hiNibble_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetBar) begin
            loNibble_q <= RESET_VAL[3:0];
            hiNibble_q <= RESET_VAL[7:4];
        end else begin
            loNibble_q <= loNibble_d;
            hiNibble_q <= hiNibble_d;
        end
    end

    assign count = {hiNibble_q, loNibble_q};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / program-counter stage: alternates FETCH and EXEC, latches the
// instruction, steps the PC past immediates or loads jump targets, and flags self-loops.
module fetch_sequencer
    import nic8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              resetBar,
    input  logic [DATA_W-1:0] romData,
    input  logic [DATA_W-1:0] dbus,
    input  logic              doJumpBar,
    input  logic              assertRom,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              execPhase,
    output logic [ADDR_W-1:0] instrAddr,
    output logic              halted
);

    phase_e            phase_q;
    phase_e            phase_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_d;
    logic [ADDR_W-1:0] instrAddr_q;
    logic [ADDR_W-1:0] instrAddr_d;
    logic              halted_q;
    logic              halted_d;
    logic              pcLoad;
    logic              pcInc;
    logic [ADDR_W-1:0] pcCount;

    pc_counter #(
        .RESET_VAL (RESET_PC)
    ) u_pcCounter (
        .clk       (clk),
        .resetBar  (resetBar),
        .load      (pcLoad),
        .loadValue (dbus),
        .incEn     (pcInc),
        .count     (pcCount)
    );

    // A jump in EXEC also consumes any immediate, since the immediate is the target.
    always_comb begin
        phase_d     = phase_q;
        ir_d        = ir_q;
        instrAddr_d = instrAddr_q;
        halted_d    = halted_q;
        pcLoad      = 1'b0;
        pcInc       = 1'b0;
        unique case (phase_q)
            PHASE_FETCH: begin
                phase_d     = PHASE_EXEC;
                ir_d        = romData;
                instrAddr_d = pcCount;
                pcInc       = 1'b1;
            end
            PHASE_EXEC: begin
                phase_d = PHASE_FETCH;
                if (!doJumpBar) begin
                    pcLoad = 1'b1;
                    if (dbus == instrAddr_q) begin
                        halted_d = 1'b1;
                    end
                end else if (assertRom) begin
                    pcInc = 1'b1;
                end
            end
            default: begin
                phase_d = PHASE_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetBar) begin
            phase_q     <= PHASE_FETCH;
            ir_q        <= '0;
            instrAddr_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            ir_q        <= ir_d;
            instrAddr_q <= instrAddr_d;
            halted_q    <= halted_d;
        end
    end

    assign pc        = pcCount;
    assign ir        = ir_q;
    assign instrAddr = instrAddr_q;
    assign halted    = halted_q;
    assign execPhase = (phase_q == PHASE_EXEC);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-level reference model checked
// every cycle, plus directed literal checks for reset, immediates, jumps, wrap and halt.
module tb_fetch_sequencer;

    logic       clk;
    logic       resetBar;
    logic [7:0] romData;
    logic [7:0] dbus;
    logic       doJumpBar;
    logic       assertRom;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       execPhase;
    logic [7:0] instrAddr;
    logic       halted;

    logic [7:0] rom [256];

    int errors = 0;
    int checks = 0;

    logic [7:0] mPc;
    logic [7:0] mIr;
    logic [7:0] mAddr;
    logic       mExec;
    logic       mHalt;
    logic       modelValid = 1'b0;

    fetch_sequencer #(
        .RESET_PC (8'h00)
    ) dut (
        .clk       (clk),
        .resetBar  (resetBar),
        .romData   (romData),
        .dbus      (dbus),
        .doJumpBar (doJumpBar),
        .assertRom (assertRom),
        .pc        (pc),
        .ir        (ir),
        .execPhase (execPhase),
        .instrAddr (instrAddr),
        .halted    (halted)
    );

    assign romData = rom[pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rb, input logic jb, input logic ar, input logic [7:0] db);
        resetBar  = rb;
        doJumpBar = jb;
        assertRom = ar;
        dbus      = db;
        @(posedge clk);
        #1;
    endtask

    // Instruction-level reference: one FETCH then one EXEC per instruction.
    always @(posedge clk) begin
        if (!resetBar) begin
            mPc        = 8'h00;
            mIr        = 8'h00;
            mAddr      = 8'h00;
            mExec      = 1'b0;
            mHalt      = 1'b0;
            modelValid = 1'b1;
        end else if (!mExec) begin
            mIr   = rom[mPc];
            mAddr = mPc;
            mPc   = mPc + 8'd1;
            mExec = 1'b1;
        end else begin
            if (!doJumpBar) begin
                if (dbus == mAddr) mHalt = 1'b1;
                mPc = dbus;
            end else if (assertRom) begin
                mPc = mPc + 8'd1;
            end
            mExec = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model pc", pc, mPc);
            checkOutput("model ir", ir, mIr);
            checkOutput("model instrAddr", instrAddr, mAddr);
            checkOutput("model execPhase", {7'd0, execPhase}, {7'd0, mExec});
            checkOutput("model halted", {7'd0, halted}, {7'd0, mHalt});
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[8'h00] = 8'h2A;
        rom[8'h40] = 8'h77;
        rom[8'hFE] = 8'h33;
        rom[8'h10] = 8'h99;
        resetBar  = 1'b0;
        doJumpBar = 1'b1;
        assertRom = 1'b0;
        dbus      = 8'h00;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("reset pc", pc, 8'h00);
        checkOutput("reset ir", ir, 8'h00);
        checkOutput("reset execPhase", {7'd0, execPhase}, 8'h00);
        checkOutput("reset halted", {7'd0, halted}, 8'h00);

        // FETCH with decoder lines active: must be ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3);
        checkOutput("first fetch ir", ir, 8'h2A);
        checkOutput("first fetch pc", pc, 8'h01);
        checkOutput("first fetch instrAddr", instrAddr, 8'h00);
        checkOutput("first fetch execPhase", {7'd0, execPhase}, 8'h01);

        $display("[TB] immediate skip and hold");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("imm skip pc", pc, 8'h02);
        checkOutput("imm skip execPhase", {7'd0, execPhase}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("fetch@02 ir", ir, 8'h02 ^ 8'h5A);
        checkOutput("fetch@02 pc", pc, 8'h03);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("no imm hold pc", pc, 8'h03);

        $display("[TB] jump");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("fetch@03 pc", pc, 8'h04);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h40);
        checkOutput("jump pc", pc, 8'h40);
        checkOutput("jump no halt", {7'd0, halted}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("fetch@40 ir", ir, 8'h77);
        checkOutput("fetch@40 instrAddr", instrAddr, 8'h40);
        checkOutput("fetch@40 pc", pc, 8'h41);

        $display("[TB] wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFE);
        checkOutput("jump FE pc", pc, 8'hFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("fetch@FE pc", pc, 8'hFF);
        checkOutput("fetch@FE ir", ir, 8'h33);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("wrap skip pc", pc, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("after wrap instrAddr", instrAddr, 8'h00);
        checkOutput("after wrap pc", pc, 8'h01);

        $display("[TB] halt");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h10);
        checkOutput("jump 10 pc", pc, 8'h10);
        checkOutput("jump 10 no halt", {7'd0, halted}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("fetch@10 ir", ir, 8'h99);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h10);
        checkOutput("self loop halted", {7'd0, halted}, 8'h01);
        checkOutput("self loop pc", pc, 8'h10);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("halt sticky", {7'd0, halted}, 8'h01);
        checkOutput("loop continues pc", pc, 8'h11);

        $display("[TB] reset during EXEC");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("pre-reset execPhase", {7'd0, execPhase}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h80);
        checkOutput("exec reset pc", pc, 8'h00);
        checkOutput("exec reset execPhase", {7'd0, execPhase}, 8'h00);
        checkOutput("exec reset halted", {7'd0, halted}, 8'h00);
        checkOutput("exec reset instrAddr", instrAddr, 8'h00);

        $display("[TB] mixed traffic");
        for (int n = 0; n < 200; n++) begin
            applyStimulus(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? instrAddr : 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
